rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit stream multiplexer.
- Successor to the team's fixed 4-bit 4:1 combinational mux.
- Each channel has a valid/ready input port. One registered output port, with the source channel index carried alongside the data.
- Two modes: fixed select (software-steered, like the old mux) and fair round-robin arbitration. Sits between multiple producers and a single downstream consumer.

Parameters:
- WIDTH, 4, data width per channel in bits.
- NCH, 4, number of input channels (≥2).
- SELW, 2, width of channel index; must equal clog2(NCH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel selected when mode=0.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0 (channel 0 highest priority). rst overrides any transfer in that cycle.
- Output register is a single-entry stage.
  - load_en = !out_valid || out_ready.
  - Downstream transfer occurs when out_valid && out_ready.
- Grant (combinational, one-hot or zero):
  - mode=0: grant[sel] = in_valid[sel]. If sel ≥ NCH, no grant.
  - mode=1: first i with in_valid[i]=1, scanning from rr_ptr upward modulo NCH (wrap NCH-1 → 0).
- Handshakes:
  - in_ready[i] = grant[i] && load_en. in_ready is never asserted for a non-granted channel.
  - Upstream transfer on channel i when in_valid[i] && in_ready[i].
- On upstream transfer: out_data←channel i data, out_ch←i, out_valid←1 at the next edge. Latency is 1 cycle from accept to out_valid.
- If load_en=1 and no grant: out_valid←0 at the next edge; out_data and out_ch hold their last values.
- If load_en=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold. All in_ready=0.
- Simultaneous downstream and upstream transfer in one cycle: the new beat replaces the old with no bubble. Full throughput is 1 beat/cycle.
- rr_ptr update:
  - On an upstream transfer in mode=1: rr_ptr←(i+1) mod NCH, where i=NCH-1 wraps to 0.
  - In mode=0, or when there is no transfer: rr_ptr holds.
- Mode change: takes effect at the next arbitration cycle. rr_ptr is preserved across mode switches. A beat already in the output register is unaffected.
- Input contract: upstream must hold in_data stable and keep in_valid high until accepted. The block does not check this.
- The old 4:1 mux behaviour is reproduced by WIDTH=4, NCH=4, mode=0, out_ready=1, with sel = {s1,s0} and 1-cycle latency.

Test Plan:
- Reset: drive rst=1 with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000; first grant after release goes to ch0.
- Fixed mode:
  - Setup: mode=0, in_data ch0..3 = 1,2,2,3, all valid, out_ready=1.
  - Stimulus: step sel 0,1,2,3.
  - Required: one cycle later, out_data = 1,2,2,3 and out_ch = 0,1,2,3; only in_ready[sel]=1.
- Round-robin fairness: mode=1, all four valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1… with one beat per cycle and no bubbles.
- Sparse round-robin: mode=1, only ch1 and ch3 valid, rr_ptr=2 → first grant ch3, then ch1, then ch3; wrap 3→0 scan is correct.
- Backpressure:
  - Setup: out_valid=1, out_ready=0 for 3 cycles.
  - Required: out_data and out_ch stable; all in_ready=0; rr_ptr unchanged.
  - Then out_ready=1: the held beat transfers, and the next beat loads in the same cycle.
- Mid-operation events:
  - Assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0 and rr_ptr=0.
  - Switch mode 1→0 with sel=2 and ch2 invalid → no grant; out_valid drops after the pending beat drains.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer.
// Two arbitration modes share one single-entry registered output stage.
// Fixed select steers the channel chosen by sel. Round-robin rotates
// priority past the most recently accepted channel.
// The index of the supplying channel travels alongside the data.
module rr_stream_mux #(
   parameter int WIDTH = 4,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] outData_q, outData_d;
   logic [SELW-1:0]  outCh_q, outCh_d;
   logic             outValid_q, outValid_d;
   logic [SELW-1:0]  rrPtr_q, rrPtr_d;

   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grantIdx;
   logic [WIDTH-1:0] grantData;
   logic             anyGrant;
   logic             loadEn;
   logic             found;

   // Pick at most one channel to grant this cycle.
   // In fixed mode the grant goes to the sel channel when it is valid. A sel
   // value beyond the last channel matches no loop index, so nothing is granted.
   // In round-robin mode the scan starts at rrPtr_q and wraps past the last
   // channel. The first valid channel found wins.
   always_comb begin
      grant     = '0;
      grantIdx  = '0;
      grantData = '0;
      found     = 1'b0;
      if (!mode) begin
         for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant[i]  = 1'b1;
               grantIdx  = SELW'(i);
               grantData = in_data[i*WIDTH +: WIDTH];
            end
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
               if (!found && in_valid[i] && (((int'(rrPtr_q) + k) % NCH) == i)) begin
                  grant[i]  = 1'b1;
                  grantIdx  = SELW'(i);
                  grantData = in_data[i*WIDTH +: WIDTH];
                  found     = 1'b1;
               end
            end
         end
      end
   end

   // The output stage can take a new beat when it is empty or draining this cycle.
   // Ready is suppressed during reset because reset discards any transfer.
   always_comb begin
      anyGrant = |grant;
      loadEn   = !outValid_q || out_ready;
      in_ready = grant & {NCH{loadEn && !rst}};
   end

   // Next state of the output stage and the round-robin pointer.
   // When the stage loads with no grant it empties, but it keeps the last
   // data and channel values. The pointer advances only on a round-robin accept.
   always_comb begin
      outData_d  = outData_q;
      outCh_d    = outCh_q;
      outValid_d = outValid_q;
      rrPtr_d    = rrPtr_q;
      if (loadEn) begin
         outValid_d = anyGrant;
         if (anyGrant) begin
            outData_d = grantData;
            outCh_d   = grantIdx;
            if (mode) begin
               rrPtr_d = (grantIdx == SELW'(NCH - 1)) ? '0 : grantIdx + SELW'(1);
            end
         end
      end
   end

   // State registers with synchronous reset. Reset gives channel 0 top priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         outData_q  <= '0;
         outCh_q    <= '0;
         outValid_q <= 1'b0;
         rrPtr_q    <= '0;
      end else begin
         outData_q  <= outData_d;
         outCh_q    <= outCh_d;
         outValid_q <= outValid_d;
         rrPtr_q    <= rrPtr_d;
      end
   end

   assign out_data  = outData_q;
   assign out_ch    = outCh_q;
   assign out_valid = outValid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: table-driven cycle checks plus a scoreboarded
// random-backpressure stream for rr_stream_mux (WIDTH=4, NCH=4).
module tb_rr_stream_mux;

   localparam int WIDTH = 4;
   localparam int NCH   = 4;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NCH*WIDTH-1:0] in_data = '0;
   logic [NCH-1:0]       in_valid = '0;
   logic [NCH-1:0]       in_ready;
   logic                 mode = 1'b0;
   logic [SELW-1:0]      sel = '0;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready = 1'b1;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   rr_stream_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic                 rst;
      logic                 mode;
      logic [SELW-1:0]      sel;
      logic [NCH-1:0]       valid;
      logic                 outReady;
      logic [NCH*WIDTH-1:0] data;
      logic [NCH-1:0]       expReady;
      logic                 expValid;
   } vec_t;

   typedef struct {
      logic [SELW-1:0]  ch;
      logic [WIDTH-1:0] data;
   } beat_t;

   vec_t  vecs[$];
   beat_t sbQ[$];
   beat_t curBeat;
   int    errors = 0;
   int    checks = 0;

   localparam logic [15:0] DRR = 16'hDCBA;
   localparam logic [15:0] DFX = 16'h3221;

   function automatic void addVec(input logic r, input logic m, input logic [SELW-1:0] s,
                                  input logic [NCH-1:0] v, input logic oR,
                                  input logic [NCH*WIDTH-1:0] d,
                                  input logic [NCH-1:0] eR, input logic eV);
      vec_t t;
      t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.outReady = oR;
      t.data = d; t.expReady = eR; t.expValid = eV;
      vecs.push_back(t);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive one table row, check ready before the edge, then check the output stage after it.
   task automatic applyStimulus(input int idx, input vec_t v);
      int    ch;
      beat_t b;
      logic  pushed;
      @(negedge clk);
      rst       = v.rst;
      mode      = v.mode;
      sel       = v.sel;
      in_valid  = v.valid;
      out_ready = v.outReady;
      in_data   = v.data;
      #1;
      checkOutput($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.expReady));
      pushed = 1'b0;
      if (v.expReady != '0) begin
         ch = 0;
         for (int i = 0; i < NCH; i++) if (v.expReady[i]) ch = i;
         b.ch   = SELW'(ch);
         b.data = v.data[ch*WIDTH +: WIDTH];
         sbQ.push_back(b);
         pushed = 1'b1;
      end
      @(posedge clk);
      #1;
      if (v.rst) begin
         curBeat.ch   = '0;
         curBeat.data = '0;
      end else if (pushed && sbQ.size() > 0) begin
         curBeat = sbQ.pop_front();
      end
      checkOutput($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.expValid));
      checkOutput($sformatf("v%0d out_ch", idx), 32'(out_ch), 32'(curBeat.ch));
      checkOutput($sformatf("v%0d out_data", idx), 32'(out_data), 32'(curBeat.data));
   endtask

   initial begin
      int    sent;
      int    recvd;
      beat_t b;
      curBeat.ch   = '0;
      curBeat.data = '0;

      // Reset with every channel valid: no ready, empty output.
      addVec(1, 0, 2'd0, 4'b1111, 1, DFX, 4'b0000, 0);
      addVec(1, 0, 2'd0, 4'b1111, 1, DFX, 4'b0000, 0);
      // Round-robin with all valid: 0,1,2,3,0,1 back to back.
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0001, 1);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0010, 1);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0100, 1);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b1000, 1);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0001, 1);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0010, 1);
      // Sparse: only ch1/ch3, pointer at 2 -> 3,1,3, then ch1 alone from pointer 0.
      addVec(0, 1, 2'd0, 4'b1010, 1, DRR, 4'b1000, 1);
      addVec(0, 1, 2'd0, 4'b1010, 1, DRR, 4'b0010, 1);
      addVec(0, 1, 2'd0, 4'b1010, 1, DRR, 4'b1000, 1);
      addVec(0, 1, 2'd0, 4'b0010, 1, DRR, 4'b0010, 1);
      // Backpressure for 3 cycles, then release loads ch2 (pointer kept at 2).
      addVec(0, 1, 2'd0, 4'b1111, 0, DRR, 4'b0000, 1);
      addVec(0, 1, 2'd0, 4'b1111, 0, DRR, 4'b0000, 1);
      addVec(0, 1, 2'd0, 4'b1111, 0, DRR, 4'b0000, 1);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0100, 1);
      // Pointer at 3, only ch1 valid: scan wraps 3->0->1.
      addVec(0, 1, 2'd0, 4'b0010, 1, DRR, 4'b0010, 1);
      // Idle: output empties, data and channel hold.
      addVec(0, 1, 2'd0, 4'b0000, 1, DRR, 4'b0000, 0);
      // Fixed select steps 0..3 on data 1,2,2,3.
      addVec(0, 0, 2'd0, 4'b1111, 1, DFX, 4'b0001, 1);
      addVec(0, 0, 2'd1, 4'b1111, 1, DFX, 4'b0010, 1);
      addVec(0, 0, 2'd2, 4'b1111, 1, DFX, 4'b0100, 1);
      addVec(0, 0, 2'd3, 4'b1111, 1, DFX, 4'b1000, 1);
      // Back to round-robin: pointer preserved at 2.
      addVec(0, 1, 2'd3, 4'b1111, 1, DRR, 4'b0100, 1);
      // Held beat, then switch to fixed sel=2 with ch2 invalid: drains, no grant.
      addVec(0, 1, 2'd0, 4'b1111, 0, DRR, 4'b0000, 1);
      addVec(0, 0, 2'd2, 4'b1011, 1, DRR, 4'b0000, 0);
      // Pointer at 3, ch1 alone -> pointer 2; reset while stalled; first grant ch0.
      addVec(0, 1, 2'd0, 4'b0010, 1, DRR, 4'b0010, 1);
      addVec(0, 1, 2'd0, 4'b1111, 0, DRR, 4'b0000, 1);
      addVec(1, 1, 2'd0, 4'b1111, 0, DRR, 4'b0000, 0);
      addVec(0, 1, 2'd0, 4'b1111, 1, DRR, 4'b0001, 1);
      addVec(0, 1, 2'd0, 4'b0000, 1, DRR, 4'b0000, 0);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

      // Fixed sel=1 stream of 8 beats under random backpressure, other channels also valid.
      sent  = 0;
      recvd = 0;
      sbQ.delete();
      for (int cyc = 0; cyc < 300 && recvd < 8; cyc++) begin
         @(negedge clk);
         rst       = 1'b0;
         mode      = 1'b0;
         sel       = 2'd1;
         out_ready = ($urandom_range(0, 2) != 0);
         in_valid  = 4'b1101 | ((sent < 8) ? 4'b0010 : 4'b0000);
         in_data   = '0;
         in_data[WIDTH +: WIDTH] = WIDTH'(sent + 5);
         #1;
         checkOutput("sb stray ready", 32'(in_ready & 4'b1101), 32'd0);
         if (out_valid && out_ready) begin
            checks++;
            if (sbQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb unexpected beat: got ch %0d data %0h, expected none", out_ch, out_data);
            end else begin
               b = sbQ.pop_front();
               if (out_ch !== b.ch || out_data !== b.data) begin
                  errors++;
                  $display("[TB] FAIL sb beat: got ch %0d data %0h expected ch %0d data %0h",
                           out_ch, out_data, b.ch, b.data);
               end
               recvd++;
            end
         end
         if (in_valid[1] && in_ready[1]) begin
            b.ch   = 2'd1;
            b.data = WIDTH'(sent + 5);
            sbQ.push_back(b);
            sent++;
         end
      end
      checkOutput("sb beats received", 32'(recvd), 32'd8);
      checkOutput("sb leftovers", 32'(sbQ.size()), 32'd0);

      @(negedge clk);
      in_valid = '0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
